// File: rtl/dm_arbiter_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
package dm_arb_pkg;

    // Arbiter sequencing: IDLE picks an owner, ISSUE drives the memory port,
    // RESP returns the ack (and read data) to the owner.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    localparam int DEF_CORES  = 4;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/dm_arbiter_rr_picker.sv
// Rotating-priority picker: returns the first set request at or above ptr,
// wrapping from CORES-1 back to 0. Purely combinational.
module rr_picker
    import dm_arb_pkg::*;
#(
    parameter int CORES = DEF_CORES,
    parameter int PW    = (CORES > 1) ? $clog2(CORES) : 1
) (
    input  logic [CORES-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [PW-1:0]    grant,
    output logic             any
);

    logic [PW:0]      sum_w [CORES];
    logic [PW-1:0]    cand  [CORES];
    logic [CORES-1:0] hit;

    // Candidate gi is the core that sits gi places above ptr (modulo CORES).
    genvar gi;
    generate
        for (gi = 0; gi < CORES; gi++) begin : g_rot
            assign sum_w[gi] = {1'b0, ptr} + (PW+1)'(gi);
            assign cand[gi]  = (sum_w[gi] >= (PW+1)'(CORES))
                             ? PW'(sum_w[gi] - (PW+1)'(CORES))
                             : sum_w[gi][PW-1:0];
            assign hit[gi]   = req[cand[gi]];
        end
    endgenerate

    // Scan from the farthest offset down so the nearest hit to ptr wins.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        for (int k = CORES - 1; k >= 0; k--) begin
            if (hit[k]) begin
                grant = cand[k];
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory arbiter: shares one single-port memory between CORES requesters
// with round-robin fairness and an optional per-owner lock for atomic
// read-modify-write sequences. One access every 3 cycles at most.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int CORES  = DEF_CORES,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CORES-1:0]         req,
    input  logic [CORES-1:0]         we,
    input  logic [CORES-1:0]         lock,
    input  logic [CORES*ADDR_W-1:0]  addr,
    input  logic [CORES*DATA_W-1:0]  wdata,
    output logic [CORES-1:0]         ack,
    output logic [DATA_W-1:0]        rdata,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam int PW = (CORES > 1) ? $clog2(CORES) : 1;

    arb_state_t         state_reg;
    logic [PW-1:0]      owner_reg;
    logic [PW-1:0]      ptr_reg;
    logic               locked_reg;
    logic               cur_we_reg;
    logic [CORES-1:0]   ack_reg;
    logic [DATA_W-1:0]  rdata_reg;
    logic               mem_en_reg;
    logic               mem_we_reg;
    logic [ADDR_W-1:0]  mem_addr_reg;
    logic [DATA_W-1:0]  mem_wdata_reg;

    logic [ADDR_W-1:0]  addr_a  [CORES];
    logic [DATA_W-1:0]  wdata_a [CORES];

    logic [PW-1:0]      rr_grant;
    logic               rr_any;
    logic               hold_lock;
    logic               win_any;
    logic [PW-1:0]      win_idx;
    logic [PW-1:0]      ptr_next;

    // Unpack the per-core address and write-data buses.
    genvar gi;
    generate
        for (gi = 0; gi < CORES; gi++) begin : g_unpack
            assign addr_a[gi]  = addr[gi*ADDR_W +: ADDR_W];
            assign wdata_a[gi] = wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_picker #(
        .CORES (CORES),
        .PW    (PW)
    ) u_picker (
        .req   (req),
        .ptr   (ptr_reg),
        .grant (rr_grant),
        .any   (rr_any)
    );

    // A held lock restricts eligibility to the owner; once the owner lets go
    // of lock, ordinary round-robin applies in the very same IDLE cycle.
    assign hold_lock = locked_reg && lock[owner_reg];
    assign win_any   = hold_lock ? req[owner_reg] : rr_any;
    assign win_idx   = hold_lock ? owner_reg : rr_grant;
    assign ptr_next  = (owner_reg == PW'(CORES - 1)) ? '0 : owner_reg + 1'b1;

    // Arbitration FSM with registered memory-port and ack outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            owner_reg     <= '0;
            ptr_reg       <= '0;
            locked_reg    <= 1'b0;
            cur_we_reg    <= 1'b0;
            ack_reg       <= '0;
            rdata_reg     <= '0;
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (locked_reg && !lock[owner_reg]) begin
                        locked_reg <= 1'b0;
                    end
                    if (win_any) begin
                        owner_reg     <= win_idx;
                        cur_we_reg    <= we[win_idx];
                        mem_en_reg    <= 1'b1;
                        mem_we_reg    <= we[win_idx];
                        mem_addr_reg  <= addr_a[win_idx];
                        mem_wdata_reg <= wdata_a[win_idx];
                        state_reg     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en_reg <= 1'b0;
                    mem_we_reg <= 1'b0;
                    ack_reg    <= CORES'(1) << owner_reg;
                    state_reg  <= RESP;
                end
                RESP: begin
                    ack_reg <= '0;
                    if (!cur_we_reg) begin
                        rdata_reg <= mem_rdata;
                    end
                    if (lock[owner_reg]) begin
                        locked_reg <= 1'b1;
                    end else begin
                        locked_reg <= 1'b0;
                        ptr_reg    <= ptr_next;
                    end
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Memory read data only arrives during RESP, so a read forwards it straight
    // through in the ack cycle; afterwards the captured copy is presented.
    assign rdata = (state_reg == RESP && !cur_we_reg) ? mem_rdata : rdata_reg;

    assign ack       = ack_reg;
    assign mem_en    = mem_en_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed testbench for dm_arbiter with a behavioural single-port memory.
module tb_dm_arbiter;

    localparam int CORES  = 4;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic                    clk;
    logic                    reset;
    logic [CORES-1:0]        req;
    logic [CORES-1:0]        we;
    logic [CORES-1:0]        lock;
    logic [CORES*ADDR_W-1:0] addr;
    logic [CORES*DATA_W-1:0] wdata;
    logic [CORES-1:0]        ack;
    logic [DATA_W-1:0]       rdata;
    logic                    mem_en;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic [DATA_W-1:0]       mem_rdata;

    // memory model with a bench-side preload port
    logic [DATA_W-1:0] mem [0:1023];
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;

    int n_cmp;
    int n_err;
    int cyc;

    dm_arbiter #(
        .CORES  (CORES),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .lock      (lock),
        .addr      (addr),
        .wdata     (wdata),
        .ack       (ack),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #2 clk = ~clk;

    always @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic poke(input int a, input int d);
        load_addr = ADDR_W'(a);
        load_data = DATA_W'(d);
        load_en   = 1'b1;
        @(posedge clk);
        #1;
        load_en   = 1'b0;
    endtask

    task automatic set_core(input int i, input logic w, input int a, input int d);
        we[i]                 = w;
        addr[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
        wdata[i*DATA_W +: DATA_W] = DATA_W'(d);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        we    = '0;
        lock  = '0;
        addr  = '0;
        wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({ack, mem_en, mem_we} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_strobes: got ack=%b en=%b we=%b want 0", ack, mem_en, mem_we);
        end
        n_cmp++;
        if ({rdata, mem_addr, mem_wdata} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got rdata=%0d addr=%0d wdata=%0d want 0", rdata, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_single_read();
        poke(5, 13);
        do_reset();
        set_core(2, 1'b0, 5, 0);
        req = 4'b0100;
        tick();
        n_cmp++;
        if ({mem_en, mem_we, mem_addr, ack} !== {1'b1, 1'b0, 10'd5, 4'b0000}) begin
            n_err++;
            $display("FAIL read_issue: got en=%b we=%b addr=%0d ack=%b want 1 0 5 0000", mem_en, mem_we, mem_addr, ack);
        end
        tick();
        n_cmp++;
        if (ack !== 4'b0100 || rdata !== 32'd13) begin
            n_err++;
            $display("FAIL read_ack: got ack=%b rdata=%0d want 0100 13", ack, rdata);
        end
        $display("read core 2 addr 5 -> %0d at cycle %0d", rdata, cyc);
        req = '0;
        tick();
        n_cmp++;
        if (ack !== 4'b0000 || rdata !== 32'd13 || mem_en !== 1'b0) begin
            n_err++;
            $display("FAIL read_after: got ack=%b rdata=%0d en=%b want 0000 13 0", ack, rdata, mem_en);
        end
    endtask

    task automatic test_single_write();
        set_core(0, 1'b1, 3, 14);
        req = 4'b0001;
        tick();
        n_cmp++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 10'd3, 32'd14}) begin
            n_err++;
            $display("FAIL write_issue: got en=%b we=%b addr=%0d wdata=%0d want 1 1 3 14", mem_en, mem_we, mem_addr, mem_wdata);
        end
        tick();
        n_cmp++;
        if (ack !== 4'b0001 || rdata !== 32'd13 || mem_en !== 1'b0) begin
            n_err++;
            $display("FAIL write_ack: got ack=%b rdata=%0d en=%b want 0001 13 0", ack, rdata, mem_en);
        end
        $display("write core 0 addr 3 <- 14 at cycle %0d", cyc);
        req = '0;
        tick();
        n_cmp++;
        if (ack !== 4'b0000 || mem[3] !== 32'd14) begin
            n_err++;
            $display("FAIL write_mem: got ack=%b mem[3]=%0d want 0000 14", ack, mem[3]);
        end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_ack;
        int         core;
        do_reset();
        for (int i = 0; i < CORES; i++) set_core(i, 1'b0, 20 + i, 0);
        req = 4'b1111;
        for (int c = 1; c <= 15; c++) begin
            tick();
            core    = (c / 3) % 4;
            exp_ack = (c % 3 == 2) ? (4'b0001 << core) : 4'b0000;
            n_cmp++;
            if (ack !== exp_ack) begin
                n_err++;
                $display("FAIL fair_ack c%0d: got %b want %b", c, ack, exp_ack);
            end
            if (c % 3 == 1) begin
                n_cmp++;
                if (mem_en !== 1'b1 || mem_addr !== ADDR_W'(20 + core)) begin
                    n_err++;
                    $display("FAIL fair_issue c%0d: got en=%b addr=%0d want 1 %0d", c, mem_en, mem_addr, 20 + core);
                end
            end
            if (ack != 0) $display("fair ack %b at cycle %0d", ack, cyc);
        end
        req = '0;
        repeat (3) tick();
    endtask

    task automatic test_locking();
        int n_ack1 = 0;
        int ack1_a = -1;
        int ack1_b = -1;
        int ack3   = -1;
        do_reset();
        poke(4, 77);
        set_core(1, 1'b0, 4, 0);
        set_core(3, 1'b0, 7, 0);
        lock = 4'b0010;
        req  = 4'b1010;
        cyc  = 0;
        for (int c = 1; c <= 20 && req != 0; c++) begin
            tick();
            if (ack[1]) begin
                n_ack1++;
                $display("lock ack core 1 at cycle %0d rdata %0d", cyc, rdata);
                if (n_ack1 == 1) begin
                    ack1_a = cyc;
                    n_cmp++;
                    if (rdata !== 32'd77) begin
                        n_err++;
                        $display("FAIL lock_read: got rdata=%0d want 77", rdata);
                    end
                    set_core(1, 1'b1, 4, 78);
                end else begin
                    ack1_b  = cyc;
                    req[1]  = 1'b0;
                    lock[1] = 1'b0;
                end
            end
            if (ack[3]) begin
                ack3   = cyc;
                req[3] = 1'b0;
                $display("lock ack core 3 at cycle %0d", cyc);
            end
        end
        n_cmp++;
        if (ack1_a != 2 || ack1_b != 5) begin
            n_err++;
            $display("FAIL lock_owner_acks: got %0d,%0d want 2,5", ack1_a, ack1_b);
        end
        n_cmp++;
        if (ack3 != 8) begin
            n_err++;
            $display("FAIL lock_waiter_ack: got cycle %0d want 8", ack3);
        end
        n_cmp++;
        if (mem[4] !== 32'd78) begin
            n_err++;
            $display("FAIL lock_write: got mem[4]=%0d want 78", mem[4]);
        end
    endtask

    task automatic test_reset_mid();
        int first = -1;
        logic [3:0] first_ack = '0;
        poke(6, 0);
        do_reset();
        set_core(2, 1'b0, 9, 0);
        req = 4'b0100;
        repeat (2) tick();
        req = '0;
        tick();
        set_core(3, 1'b1, 6, 55);
        req = 4'b1000;
        tick();
        n_cmp++;
        if (mem_en !== 1'b1 || mem_addr !== 10'd6) begin
            n_err++;
            $display("FAIL rstmid_issue: got en=%b addr=%0d want 1 6", mem_en, mem_addr);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({ack, mem_en, mem_we, mem_addr, mem_wdata, rdata} !== '0) begin
            n_err++;
            $display("FAIL rstmid_outputs: got ack=%b en=%b we=%b addr=%0d wdata=%0d rdata=%0d want 0",
                     ack, mem_en, mem_we, mem_addr, mem_wdata, rdata);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (ack !== 4'b0000 || mem_en !== 1'b0) begin
                n_err++;
                $display("FAIL rstmid_hold: got ack=%b en=%b want 0000 0", ack, mem_en);
            end
        end
        n_cmp++;
        if (mem[6] !== 32'd0) begin
            n_err++;
            $display("FAIL rstmid_cancel: got mem[6]=%0d want 0", mem[6]);
        end
        set_core(1, 1'b0, 2, 0);
        req   = 4'b1010;
        reset = 1'b0;
        cyc   = 0;
        for (int c = 1; c <= 6 && first < 0; c++) begin
            tick();
            if (ack != 0) begin
                first     = cyc;
                first_ack = ack;
            end
        end
        $display("post-reset first ack %b at cycle %0d", first_ack, first);
        n_cmp++;
        if (first != 2 || first_ack !== 4'b0010) begin
            n_err++;
            $display("FAIL rstmid_restart: got ack=%b at %0d want 0010 at 2", first_ack, first);
        end
        req = '0;
        repeat (3) tick();
    endtask

    // Each active core services jobs k = core, core+n, ... ; reads capture rdata.
    task automatic run_phase(input int ncores, input logic is_write,
                             input int vals[10], output int got[10], output logic done);
        int jobs[CORES];
        done = 1'b0;
        for (int i = 0; i < CORES; i++) jobs[i] = 99;
        for (int k = 0; k < 10; k++) got[k] = -1;
        for (int i = 0; i < ncores; i++) begin
            jobs[i] = i;
            set_core(i, is_write, i, vals[i]);
            req[i] = 1'b1;
        end
        for (int c = 0; c < 60 && !done; c++) begin
            tick();
            for (int i = 0; i < ncores; i++) begin
                if (ack[i]) begin
                    if (!is_write) got[jobs[i]] = int'(rdata);
                    $display("sort core %0d %s addr %0d data %0d", i, is_write ? "wr" : "rd",
                             jobs[i], is_write ? vals[jobs[i]] : int'(rdata));
                    jobs[i] += ncores;
                    if (jobs[i] < 10) set_core(i, is_write, jobs[i], vals[jobs[i]]);
                    else req[i] = 1'b0;
                end
            end
            if (req == 0) done = 1'b1;
        end
        req = '0;
    endtask

    task automatic test_sort_integration(input int ncores);
        int    unsorted[10] = '{14, 12, 13, 5, 9, 11, 3, 6, 7, 10};
        int    expected[10] = '{14, 13, 12, 11, 10, 9, 7, 6, 5, 3};
        int    buffer[10];
        int    dummy[10];
        int    t;
        logic  ok_rd, ok_wr;
        time   t0;
        for (int k = 0; k < 10; k++) poke(k, unsorted[k]);
        do_reset();
        t0 = $time;
        run_phase(ncores, 1'b0, unsorted, buffer, ok_rd);
        for (int a = 0; a < 9; a++)
            for (int b = 0; b < 9 - a; b++)
                if (buffer[b] < buffer[b+1]) begin
                    t = buffer[b]; buffer[b] = buffer[b+1]; buffer[b+1] = t;
                end
        run_phase(ncores, 1'b1, buffer, dummy, ok_wr);
        n_cmp++;
        if (!ok_rd || !ok_wr || ($time - t0) > 400) begin
            n_err++;
            $display("FAIL sort%0d_time: got done=%b%b elapsed=%0t want done within 400", ncores, ok_rd, ok_wr, $time - t0);
        end
        for (int k = 0; k < 10; k++) begin
            n_cmp++;
            if (mem[k] !== DATA_W'(expected[k])) begin
                n_err++;
                $display("FAIL sort%0d_mem[%0d]: got %0d want %0d", ncores, k, mem[k], expected[k]);
            end
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        cyc     = 0;
        load_en = 1'b0;
        load_addr = '0;
        load_data = '0;
        mem_rdata = '0;
        reset   = 1'b1;
        req     = '0;
        we      = '0;
        lock    = '0;
        addr    = '0;
        wdata   = '0;
        test_reset();
        test_single_read();
        test_single_write();
        test_fairness();
        test_locking();
        test_reset_mid();
        test_sort_integration(1);
        test_sort_integration(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter CORES, default 4, SHALL set the number of requesting cores (2..8).
REQ-002 Parameter ADDR_W, default 10, SHALL set the data-memory word-address width.
REQ-003 Parameter DATA_W, default 32, SHALL set the data word width.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be asynchronous, active-high reset.
REQ-006 req  input  CORES  SHALL carry per-core access request, held high until that core's ack.
REQ-007 we  input  CORES  SHALL carry per-core write enable (1 = write, 0 = read).
REQ-008 lock  input  CORES  SHALL carry per-core request to keep ownership after the current access.
REQ-009 addr  input  CORES*ADDR_W  SHALL carry per-core word addresses, with core i at bits [i*ADDR_W +: ADDR_W].
REQ-010 wdata  input  CORES*DATA_W  SHALL carry per-core write data, packed the same way as addr.
REQ-011 ack  output  CORES  SHALL carry per-core one-cycle completion pulses.
REQ-012 rdata  output  DATA_W  SHALL be the read data broadcast to all cores, valid during the ack cycle.
REQ-013 mem_en, mem_we  output  1 each  SHALL be the memory-port strobe and write enable.
REQ-014 mem_addr, mem_wdata  output  ADDR_W, DATA_W  SHALL be the memory-port address and write data.
REQ-015 mem_rdata  input  DATA_W  SHALL be the memory read data, valid the cycle after mem_en.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE and RESP; ISSUE and RESP SHALL each last exactly one cycle.
REQ-017 In IDLE with any eligible req, the block SHALL register winner owner and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-018 Unlocked winner selection SHALL be round-robin, picking the first req set scanning from ptr upward and wrapping from CORES-1 to 0.
REQ-019 In ISSUE, mem_en SHALL be 1 and mem_we/mem_addr/mem_wdata SHALL equal the owner's we/addr/wdata.
REQ-020 In all other states mem_en and mem_we SHALL be 0.
REQ-021 In RESP, ack[owner] SHALL be 1; on a read, rdata SHALL load mem_rdata; on a write, rdata SHALL hold its previous value.
REQ-022 Latency: req sampled in IDLE at cycle N SHALL give mem_en at N+1 and ack at N+2; peak throughput SHALL be one access per 3 cycles.
REQ-023 On leaving RESP with lock[owner]=0, ptr SHALL become (owner+1) mod CORES and locked SHALL clear.
REQ-024 On leaving RESP with lock[owner]=1, locked SHALL set and ptr SHALL be unchanged.
REQ-025 While locked, IDLE SHALL consider only req[owner]; other requesters SHALL wait.
REQ-026 While locked, if lock[owner]=0 in IDLE, locked SHALL clear and normal round-robin arbitration SHALL occur in that same cycle.
REQ-027 A req dropped after grant SHALL NOT abort the access; the memory access and ack SHALL still complete.
REQ-028 Only one ack bit SHALL ever be high, and it SHALL be high for exactly one cycle per access.
REQ-029 lock is sampled only in RESP and IDLE; lock asserted by a non-owner SHALL have no effect.

Reset
REQ-030 Asserting reset SHALL immediately force state=IDLE, ptr=0, owner=0, locked=0, ack=0, rdata=0, mem_en=0, mem_we=0, mem_addr=0 and mem_wdata=0.
REQ-031 Reset mid-access SHALL abandon the access with no ack issued; an in-flight ISSUE cycle SHALL be cancelled.
REQ-032 The first arbitration after reset deassertion SHALL start scanning at core 0.

Structure
REQ-033 Package dm_arb_pkg SHALL hold the state enum (IDLE/ISSUE/RESP) and the default CORES/ADDR_W/DATA_W constants.
REQ-034 The rotating priority selection SHALL be the combinational sub-module rr_picker (inputs req, ptr; outputs grant index, any).
REQ-035 The owner and ptr registers SHALL be $clog2(CORES) bits wide.

Verification
REQ-036 The bench SHALL check a single read: core 2 reads addr 5 with mem[5]=13 -> mem_en at N+1, ack[2] and rdata=13 at N+2.
REQ-037 The bench SHALL check a single write: core 0 writes 14 to addr 3 -> mem_we=1, mem_addr=3, mem_wdata=14 at N+1, ack[0] at N+2, rdata unchanged.
REQ-038 The bench SHALL check fairness: all 4 cores hold req from reset -> grant order 0,1,2,3,0, acks at cycles 2,5,8,11,14.
REQ-039 The bench SHALL check locking: core 1 holds lock over read addr 4 then write addr 4 while core 3 requests -> core 3 is acked only after core 1's second ack and lock drop.
REQ-040 The bench SHALL check reset mid-access: reset asserted during ISSUE -> no ack, all outputs 0, and the next arbitration starts at core 0.
REQ-041 The bench SHALL check sort integration: 1-core and 4-core CPUs sort {14,12,13,5,9,11,3,6,7,10} -> memory[0..9] = 14 13 12 11 10 9 7 6 5 3 within 400 time units.
